mem_access_unit: RTL and testbench

Stage-4 memory access unit of the WISC-S15 five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It passes ALU results through for non-memory instructions. It executes LW/SW against a variable-latency data memory using a req/ack handshake, stalling the upstream stages until the access completes. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/wisc_s15_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 40 ++++
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_s15_pkg.sv
// Shared WISC-S15 pipeline definitions: datapath widths and the memory
// access unit's state encoding.
package wisc_s15_pkg;

  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage : wisc_s15_pkg

// File: rtl/mem_timeout_ctr.sv
// Watchdog for outstanding data-memory accesses: counts BUSY cycles without
// an ack and flags the final cycle before the access must be abandoned.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stray enable can never wrap past the abort point.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule : mem_timeout_ctr

// File: rtl/mem_access_unit.sv
// WISC-S15 stage-4 memory access unit: passes ALU results to MEM/WB and runs
// LW/SW against a req/ack data memory, stalling upstream until completion.
module mem_access_unit
  import wisc_s15_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mem_to_reg,
  input  logic                  reg_to_mem,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] reg_rd,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     store_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [WORD_W-1:0]     wb_data,
  output logic                  mem_err
);

  mem_state_t            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [WORD_W-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [REG_ADDR_W-1:0] rd_cap_q, rd_cap_d;
  logic                  rw_cap_q, rw_cap_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [WORD_W-1:0]     wb_data_q, wb_data_d;
  logic                  mem_err_q, mem_err_d;

  logic memop;
  logic ack_seen;
  logic wd_clear, wd_enable, wd_expired;

  assign memop    = in_valid & (mem_to_reg | reg_to_mem);
  assign ack_seen = mem_ack & mem_req_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rd_cap_d       = rd_cap_q;
    rw_cap_d       = rw_cap_q;
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    mem_err_d      = 1'b0;
    stall          = 1'b0;
    wd_clear       = 1'b0;
    wd_enable      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memop) begin
          // LW wins when both opcode bits are set, hence the masked write enable.
          stall       = 1'b1;
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = reg_to_mem & ~mem_to_reg;
          mem_addr_d  = alu_result;
          mem_wdata_d = store_data;
          rd_cap_d    = reg_rd;
          rw_cap_d    = reg_write;
          wb_valid_d  = 1'b0;
          wd_clear    = 1'b1;
        end else if (in_valid) begin
          wb_valid_d     = 1'b1;
          wb_reg_write_d = reg_write;
          wb_rd_d        = reg_rd;
          wb_data_d      = alu_result;
        end else begin
          wb_valid_d     = 1'b0;
          wb_reg_write_d = 1'b0;
        end
      end
      BUSY: begin
        if (ack_seen) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_cap_q;
          if (mem_we_q) begin
            wb_reg_write_d = 1'b0;
            wb_data_d      = mem_wdata_q;
          end else begin
            wb_reg_write_d = rw_cap_q;
            wb_data_d      = mem_rdata;
          end
        end else if (wd_expired) begin
          // Abort: release the pipeline and retire the instruction as a no-op.
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          mem_err_d      = 1'b1;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_data_d      = '0;
        end else begin
          stall      = 1'b1;
          wd_enable  = 1'b1;
          wb_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_cap_q       <= '0;
      rw_cap_q       <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_cap_q       <= rd_cap_d;
      rw_cap_q       <= rw_cap_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_err      = mem_err_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver plays the data memory and
// pushes expected writebacks; a monitor pops and compares them.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, mem_to_reg, reg_to_mem, reg_write, mem_ack;
  logic [3:0]  reg_rd, wb_rd;
  logic [15:0] alu_result, store_data, mem_rdata, mem_addr, mem_wdata, wb_data;
  logic        stall, mem_req, mem_we, wb_valid, wb_reg_write, mem_err;

  typedef struct {
    logic [3:0]  rd;
    logic        rw;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_to_reg(mem_to_reg),
    .reg_to_mem(reg_to_mem), .reg_write(reg_write), .reg_rd(reg_rd),
    .alu_result(alu_result), .store_data(store_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Monitor: every writeback must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mem_err !== 1'b0 || wb_valid !== 1'b0) begin
        checks++;
        if (wb_valid !== 1'b1) begin
          failures++;
          $display("FAIL mem_err_without_wb got wb_valid=%b mem_err=%b expected wb_valid=1", wb_valid, mem_err);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected got data=%h rd=%0d expected no writeback", wb_data, wb_rd);
        end else begin
          e = exp_q.pop_front();
          if (wb_reg_write !== e.rw || wb_data !== e.data || mem_err !== e.err ||
              (!e.err && wb_rd !== e.rd)) begin
            failures++;
            $display("FAIL wb_payload got rw=%b rd=%0d data=%h err=%b expected rw=%b rd=%0d data=%h err=%b",
                     wb_reg_write, wb_rd, wb_data, mem_err, e.rw, e.rd, e.data, e.err);
          end
        end
      end
    end
  end

  // Present one instruction and act as the data memory until it retires.
  // ack_n < 0 means the memory never answers; exp_stall < 0 skips that count.
  task automatic run_instr(input string name, input logic lw, input logic sw,
                           input logic rw, input logic [3:0] rd,
                           input logic [15:0] alu, input logic [15:0] sd,
                           input int ack_n, input logic [15:0] rdata,
                           input int exp_stall);
    exp_t e;
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    int   cyc       = 0;
    int   exp_req;
    bit   done      = 1'b0;
    bit   is_mem    = lw | sw;
    e.rd  = rd;
    e.err = 1'b0;
    if (!is_mem)       begin e.rw = rw;   e.data = alu;    end
    else if (ack_n < 0) begin e.rw = 1'b0; e.data = 16'h0; e.err = 1'b1; end
    else if (lw)       begin e.rw = rw;   e.data = rdata;  end
    else               begin e.rw = 1'b0; e.data = sd;     end
    exp_req = !is_mem ? 0 : (ack_n < 0 ? TO : ack_n + 1);
    exp_q.push_back(e);
    in_valid = 1'b1; mem_to_reg = lw; reg_to_mem = sw; reg_write = rw;
    reg_rd = rd; alu_result = alu; store_data = sd;
    while (!done && cyc < 50) begin
      if (mem_req === 1'b1) begin
        req_cnt++;
        checks++;
        if (mem_addr !== alu || mem_we !== (sw & ~lw) || mem_wdata !== sd) begin
          failures++;
          $display("FAIL %s_mem_bus got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   name, mem_addr, mem_we, mem_wdata, alu, sw & ~lw, sd);
        end
        mem_ack   = (req_cnt - 1 == ack_n);
        mem_rdata = mem_ack ? rdata : ~rdata;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (stall === 1'b1) stall_cnt++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    mem_ack = 1'b0; in_valid = 1'b0; mem_to_reg = 1'b0; reg_to_mem = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_retire got stall still high after %0d cycles expected retirement", name, cyc);
    end
    checks++;
    if (req_cnt != exp_req) begin
      failures++;
      $display("FAIL %s_req_cycles got %0d expected %0d", name, req_cnt, exp_req);
    end
    if (exp_stall >= 0) begin
      checks++;
      if (stall_cnt != exp_stall) begin
        failures++;
        $display("FAIL %s_stall_cycles got %0d expected %0d", name, stall_cnt, exp_stall);
      end
    end
    checks++;
    if (wb_valid !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_wb_latency got wb_valid=%b mem_req=%b expected wb_valid=1 mem_req=0",
               name, wb_valid, mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mem_to_reg = 1'b0; reg_to_mem = 1'b0;
    reg_write = 1'b0; reg_rd = 4'h0; alu_result = 16'h0; store_data = 16'h0;
    mem_rdata = 16'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, mem_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h wbv=%b wbrw=%b rd=%0d data=%h err=%b stall=%b expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, mem_err, stall);
    end
  endtask

  task automatic test_idle_ack();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL idle_ack got req=%b wb_valid=%b stall=%b expected 0 0 0", mem_req, wb_valid, stall);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; mem_to_reg = 1'b1; reg_to_mem = 1'b0; reg_write = 1'b1;
    reg_rd = 4'd9; alu_result = 16'h0077; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mem_to_reg = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_enter got mem_req=%b expected 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_clear got req=%b stall=%b wb_valid=%b err=%b expected 0 0 0 0",
               mem_req, stall, wb_valid, mem_err);
    end
    rst = 1'b0;
    run_instr("lw_after_rst", 1'b1, 1'b0, 1'b1, 4'd9, 16'h0077, 16'h0, 1, 16'h5A5A, 2);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_lw",  1'b1, 1'b0, 1'b1, 4'd4, 16'h0100, 16'h1111, 1, 16'hC0DE, 2);
    run_instr("b2b_sw",  1'b0, 1'b1, 1'b0, 4'd5, 16'h0102, 16'h2222, 1, 16'hDEAD, 2);
    run_instr("b2b_add", 1'b0, 1'b0, 1'b1, 4'd6, 16'h3333, 16'h0, 0, 16'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    run_instr("add",      1'b0, 1'b0, 1'b1, 4'd3,  16'h1234, 16'h0,    0,  16'h0,    0);
    run_instr("nop_rw0",  1'b0, 1'b0, 1'b0, 4'd7,  16'h8001, 16'h0,    0,  16'h0,    0);
    run_instr("lw_ack2",  1'b1, 1'b0, 1'b1, 4'd2,  16'h0040, 16'h0,    2,  16'hBEEF, 3);
    run_instr("sw_ack0",  1'b0, 1'b1, 1'b1, 4'd1,  16'h0010, 16'h00AA, 0,  16'hFFFF, 1);
    run_instr("lw_both",  1'b1, 1'b1, 1'b1, 4'd12, 16'h0200, 16'h4444, 0,  16'h9876, 1);
    test_idle_ack();
    run_instr("timeout",  1'b1, 1'b0, 1'b1, 4'd8,  16'h0300, 16'h0,    -1, 16'h1357, -1);
    run_instr("post_to",  1'b0, 1'b0, 1'b1, 4'd10, 16'hABCD, 16'h0,    0,  16'h0,    0);
    test_reset_mid_access();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_access_unit
